alu_control_regfile: RTL and testbench
======================================

# alu_control_regfile

Single-cycle RV32I integer execution block: combines instruction decode (control), a 32×32-bit register file and a 32-bit ALU. It sits behind the core's fetch stage, executes register-register (OP, 0x33) and register-immediate (OP-IMM, 0x13) instructions, and raises a sticky halt on ECALL (0x73). PC sequencing and memory access stay in the enclosing core.

## Interface
- No parameters.
- clk  input  1  single clock; all state updates on rising edge.
- rst_b  input  1  asynchronous, active-low reset.
- inst  input  32  current instruction word; valid every cycle while not halted.
- halted  output  1  sticky halt flag, set by ECALL.
- rd_we  output  1  register write strobe for the current instruction (combinational).
- rd_num  output  5  destination register index, inst[11:7].
- rd_data  output  32  ALU result to be written (combinational).
- dbg_num  input  5  debug read index.
- dbg_data  output  32  contents of register dbg_num (combinational, x0 reads 0).

## Operation
- Decode: opcode=inst[6:0], rd=inst[11:7], funct3=inst[14:12], rs1=inst[19:15], rs2=inst[24:20], funct7=inst[31:25].
- Immediate: inst[31:20] sign-extended to 32 bits; shift amount = low 5 bits of the operand.
- Operand A = x[rs1]. Operand B = x[rs2] for 0x33, immediate for 0x13.
- ALU op code (4 bits): ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
- 0x33: funct3 0 → ADD (funct7 0x00) / SUB (0x20); 1 SLL; 2 SLT; 3 SLTU; 4 XOR; 5 SRL (0x00) / SRA (0x20); 6 OR; 7 AND. Any other funct7 → illegal.
- 0x13: funct3 0 ADDI; 2 SLTI; 3 SLTIU; 4 XORI; 6 ORI; 7 ANDI; 1 SLLI (funct7 0x00); 5 SRLI (0x00) / SRAI (0x20).
- Arithmetic wraps modulo 2^32; SLT signed, SLTU unsigned, result 0 or 1; SRA sign-fills.
- rd_we = 1 only for a legal 0x33/0x13 instruction with halted=0; rd_data is still driven for illegal ones but not written.
- 0x73 (any fields): sets halted; no register write. All other opcodes: no-op.
- Register file: x0 reads 0 always, writes to x0 discarded. Two combinational read ports plus debug port.
- Write-then-read: reads in the same cycle as a write return the old value; the new value is visible after the edge.

## Timing
- Decode, operand select, ALU: purely combinational, zero-cycle latency from inst to rd_data/rd_we.
- Register write: committed on the rising clk edge while rd_we=1.
- halted: set on the rising edge at which inst is ECALL; remains 1 until reset; rd_we forced 0 from then on.
- Reset (rst_b=0, asynchronous): all 32 registers → 0, halted → 0; outputs settle combinationally from the cleared state. Reset mid-execution discards any pending write that edge.
- Back-to-back dependent instructions work without stalls (writeback at the edge, read next cycle).

## Configuration
- ALU_SHIFT_EN defined: SLL/SRL/SRA/SLLI/SRLI/SRAI implemented as above.
- ALU_SHIFT_EN undefined: shift encodings (funct3 1 and 5 under 0x33/0x13) decode as illegal: rd_we=0, no halt, register file unchanged; ALU shifter logic omitted.

## Test plan
- Reset then ADDI x1,x0,5 (0x00500093) → rd_data=5, rd_we=1; next cycle dbg_num=1 → 5.
- ADDI x2,x0,-1 (0xFFF00113) then ADD x3,x1,x2 → x2=0xFFFFFFFF, x3=4; SUB x4,x1,x2 → 6.
- SLT/SLTU x5,x2,x1 → 1 / 0; SRAI x6,x2,4 → 0xFFFFFFFF; SRLI x7,x2,28 → 0xF (with ALU_SHIFT_EN; without, x6/x7 stay 0).
- ADDI x0,x0,7 → rd_we may pulse but dbg_num=0 reads 0.
- ECALL (0x00000073) → halted=1 after edge; subsequent ADDI x1,x0,9 leaves x1=5, rd_we=0.
- Assert rst_b low mid-sequence → halted=0 and all registers read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_control_regfile_if.sv
// Execute-block bus: instruction in, writeback/halt status out, plus a debug read port.
interface alu_control_regfile_if;
  logic [31:0] inst;
  logic        halted;
  logic        rd_we;
  logic [4:0]  rd_num;
  logic [31:0] rd_data;
  logic [4:0]  dbg_num;
  logic [31:0] dbg_data;

  modport master (
    output inst, dbg_num,
    input  halted, rd_we, rd_num, rd_data, dbg_data
  );

  modport slave (
    input  inst, dbg_num,
    output halted, rd_we, rd_num, rd_data, dbg_data
  );
endinterface

// File: rtl/alu_control_regfile.sv
// Single-cycle RV32I OP/OP-IMM execute block: decode, 32x32 register file, ALU, sticky ECALL halt.
// Define ALU_SHIFT_EN to implement the shift instructions; otherwise they decode as illegal.
module alu_control_regfile (
  input  logic                 clk,
  input  logic                 rst_b,
  alu_control_regfile_if.slave bus
);
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  logic [31:0] regs [32];
  logic        halted;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm, op_a, op_b, alu_res;
  alu_op_t     alu_op;
  logic        legal, is_op, is_imm, write_en;

  assign opcode = bus.inst[6:0];
  assign rd     = bus.inst[11:7];
  assign funct3 = bus.inst[14:12];
  assign rs1    = bus.inst[19:15];
  assign rs2    = bus.inst[24:20];
  assign funct7 = bus.inst[31:25];
  assign imm    = {{20{bus.inst[31]}}, bus.inst[31:20]};
  assign is_op  = (opcode == OPC_OP);
  assign is_imm = (opcode == OPC_OP_IMM);

  // x0 is hardwired to zero on every read port regardless of array contents.
  assign op_a = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign op_b = is_op ? ((rs2 == 5'd0) ? '0 : regs[rs2]) : imm;

  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b0;
    if (is_op || is_imm) begin
      case (funct3)
        3'd0: begin
          alu_op = (is_op && funct7 == 7'h20) ? ALU_SUB : ALU_ADD;
          legal  = is_imm || funct7 == 7'h00 || funct7 == 7'h20;
        end
`ifdef ALU_SHIFT_EN
        3'd1: begin
          alu_op = ALU_SLL;
          legal  = (funct7 == 7'h00);
        end
        3'd5: begin
          alu_op = (funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
          legal  = (funct7 == 7'h00) || (funct7 == 7'h20);
        end
`endif
        3'd2: begin alu_op = ALU_SLT;  legal = is_imm || funct7 == 7'h00; end
        3'd3: begin alu_op = ALU_SLTU; legal = is_imm || funct7 == 7'h00; end
        3'd4: begin alu_op = ALU_XOR;  legal = is_imm || funct7 == 7'h00; end
        3'd6: begin alu_op = ALU_OR;   legal = is_imm || funct7 == 7'h00; end
        3'd7: begin alu_op = ALU_AND;  legal = is_imm || funct7 == 7'h00; end
        default: ;
      endcase
    end
  end

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
`ifdef ALU_SHIFT_EN
      ALU_SLL:  alu_res = op_a << op_b[4:0];
      ALU_SRL:  alu_res = op_a >> op_b[4:0];
      ALU_SRA:  alu_res = $signed(op_a) >>> op_b[4:0];
`endif
      ALU_SLT:  alu_res = {31'b0, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_res = {31'b0, (op_a < op_b)};
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      default:  alu_res = '0;
    endcase
  end

  assign write_en     = legal && !halted;
  assign bus.rd_we    = write_en;
  assign bus.rd_num   = rd;
  assign bus.rd_data  = alu_res;
  assign bus.halted   = halted;
  assign bus.dbg_data = (bus.dbg_num == 5'd0) ? '0 : regs[bus.dbg_num];

  // Writeback and halt both commit on the edge; reset clears the whole file asynchronously.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      halted <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      if (write_en && rd != 5'd0) regs[rd] <= alu_res;
      if (opcode == OPC_SYSTEM) halted <= 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_control_regfile.sv
// Directed plus randomized bench for alu_control_regfile against an instruction-level reference model.
`timescale 1ns/100ps
module tb_alu_control_regfile;
  logic clk;
  logic rst_b;
  int   checks;
  int   failures;

  logic [31:0] m_regs [32];
  logic        m_halted;

  alu_control_regfile_if bus ();

  alu_control_regfile dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  // Architectural meaning of one instruction given the model register state.
  function automatic void model_exec(input logic [31:0] ins, output logic legal,
                                     output logic [31:0] res);
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic        shifts_on;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    a   = m_regs[ins[19:15]];
    b   = (opc == 7'h33) ? m_regs[ins[24:20]] : {{20{ins[31]}}, ins[31:20]};
    sh  = b[4:0];
`ifdef ALU_SHIFT_EN
    shifts_on = 1'b1;
`else
    shifts_on = 1'b0;
`endif
    legal = 1'b0;
    res   = 32'h0;
    if (opc == 7'h33 || opc == 7'h13) begin
      case (f3)
        3'd0: begin
          if (opc == 7'h13 || f7 == 7'h00) begin legal = 1'b1; res = a + b; end
          else if (f7 == 7'h20)            begin legal = 1'b1; res = a - b; end
        end
        3'd1: begin legal = shifts_on && f7 == 7'h00; res = a << sh; end
        3'd5: begin
          legal = shifts_on && (f7 == 7'h00 || f7 == 7'h20);
          res   = (f7 == 7'h20) ? 32'($signed(a) >>> sh) : a >> sh;
        end
        3'd2: begin legal = opc == 7'h13 || f7 == 7'h00; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        3'd3: begin legal = opc == 7'h13 || f7 == 7'h00; res = (a < b) ? 32'd1 : 32'd0; end
        3'd4: begin legal = opc == 7'h13 || f7 == 7'h00; res = a ^ b; end
        3'd6: begin legal = opc == 7'h13 || f7 == 7'h00; res = a | b; end
        default: begin legal = opc == 7'h13 || f7 == 7'h00; res = a & b; end
      endcase
    end
  endfunction

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one instruction for a full cycle, check combinational outputs, then advance the model.
  task automatic apply_stimulus(input logic [31:0] ins, input logic [4:0] dn);
    logic        legal;
    logic [31:0] res;
    logic        exp_we;
    @(negedge clk);
    bus.inst    = ins;
    bus.dbg_num = dn;
    #2;
    model_exec(ins, legal, res);
    exp_we = legal && !m_halted;
    check_output("rd_we",    {31'b0, bus.rd_we},  {31'b0, exp_we});
    check_output("rd_num",   {27'b0, bus.rd_num}, {27'b0, ins[11:7]});
    if (legal) check_output("rd_data", bus.rd_data, res);
    check_output("dbg_data", bus.dbg_data, m_regs[dn]);
    check_output("halted",   {31'b0, bus.halted}, {31'b0, m_halted});
    if (exp_we && ins[11:7] != 5'd0) m_regs[ins[11:7]] = res;
    if (ins[6:0] == 7'h73) m_halted = 1'b1;
  endtask

  task automatic peek(input logic [4:0] idx, input logic [31:0] exp, input string tag);
    @(negedge clk);
    bus.inst    = 32'h0;
    bus.dbg_num = idx;
    #2;
    check_output(tag, bus.dbg_data, exp);
  endtask

  initial begin
    logic [31:0] ins;
    logic [6:0]  f7;
    logic [6:0]  opc;
    logic [2:0]  f3;
    int          sel;
    checks      = 0;
    failures    = 0;
    m_halted    = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    rst_b       = 1'b0;
    bus.inst    = 32'h0;
    bus.dbg_num = 5'd0;
    #12;
    check_output("reset_halted", {31'b0, bus.halted}, 32'h0);
    @(negedge clk);
    rst_b = 1'b1;
    $display("[TB] directed sequence");

    apply_stimulus(32'h00500093, 5'd0);
    apply_stimulus(32'hFFF00113, 5'd1);
    apply_stimulus(r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 5'd2);
    apply_stimulus(r_type(7'h20, 5'd2, 5'd1, 3'd0, 5'd4), 5'd3);
    apply_stimulus(r_type(7'h00, 5'd1, 5'd2, 3'd2, 5'd5), 5'd4);
    apply_stimulus(r_type(7'h00, 5'd1, 5'd2, 3'd3, 5'd5), 5'd5);
    apply_stimulus(i_type({7'h20, 5'd4}, 5'd2, 3'd5, 5'd6), 5'd5);
    apply_stimulus(i_type({7'h00, 5'd28}, 5'd2, 3'd5, 5'd7), 5'd6);
    apply_stimulus(i_type(12'd7, 5'd0, 3'd0, 5'd0), 5'd7);
    apply_stimulus(r_type(7'h01, 5'd2, 5'd1, 3'd0, 5'd8), 5'd0);

    peek(5'd1, 32'd5,        "x1_const");
    peek(5'd2, 32'hFFFFFFFF, "x2_const");
    peek(5'd3, 32'd4,        "x3_const");
    peek(5'd4, 32'd6,        "x4_const");
    peek(5'd5, 32'd0,        "x5_sltu_const");
    peek(5'd0, 32'd0,        "x0_const");
    peek(5'd8, 32'd0,        "x8_illegal_const");
`ifdef ALU_SHIFT_EN
    peek(5'd6, 32'hFFFFFFFF, "x6_srai_const");
    peek(5'd7, 32'h0000000F, "x7_srli_const");
`else
    peek(5'd6, 32'h0, "x6_noshift_const");
    peek(5'd7, 32'h0, "x7_noshift_const");
`endif

    apply_stimulus(32'h00000073, 5'd1);
    apply_stimulus(i_type(12'd9, 5'd0, 3'd0, 5'd1), 5'd1);
    peek(5'd1, 32'd5, "x1_after_halt");
    check_output("halted_sticky", {31'b0, bus.halted}, 32'h1);

    $display("[TB] asynchronous reset mid-cycle");
    @(negedge clk);
    bus.inst = i_type(12'd9, 5'd0, 3'd0, 5'd1);
    #2;
    rst_b = 1'b0;
    #0.2;
    check_output("async_rst_halted", {31'b0, bus.halted}, 32'h0);
    check_output("async_rst_rd_we",  {31'b0, bus.rd_we},  32'h1);
    for (int i = 1; i < 8; i++) begin
      bus.dbg_num = 5'(i);
      #0.3;
      check_output("async_rst_reg", bus.dbg_data, 32'h0);
    end
    @(posedge clk);
    #1;
    bus.dbg_num = 5'd1;
    #0.5;
    check_output("rst_discards_write", bus.dbg_data, 32'h0);
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_halted = 1'b0;
    @(negedge clk);
    bus.inst = 32'h0;
    rst_b    = 1'b1;

    $display("[TB] randomized sequence");
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      f3  = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0, 2:    f7 = 7'h00;
        1:       f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      if (sel < 5)      opc = 7'h33;
      else if (sel < 9) opc = 7'h13;
      else              opc = ($urandom_range(0, 1) == 0) ? 7'h03 : 7'h37;
      ins = {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), f3,
             5'($urandom_range(0, 7)), opc};
      if (opc == 7'h13 && f3 != 3'd1 && f3 != 3'd5 && $urandom_range(0, 1) == 1)
        ins[31:20] = 12'($urandom);
      apply_stimulus(ins, 5'($urandom_range(0, 31)));
    end

    apply_stimulus(32'hFFFFFFF3, 5'd3);
    apply_stimulus(i_type(12'h7FF, 5'd3, 3'd0, 5'd3), 5'd3);
    apply_stimulus(r_type(7'h00, 5'd3, 5'd3, 3'd0, 5'd4), 5'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
